class_decision: RTL and testbench

- Downstream of the hidden/output neuron layer. Consumes the three output-neuron activations (10-bit unsigned each) and picks the winning class with a sequential argmax.
- Applies a confidence floor and a consecutive-frame persistence counter, then raises the drowsiness alarm.
- Single clock domain. Drives the alarm/indicator logic and the frame-result register.

---
 rtl/class_decision_pkg.sv | 28 ++
 rtl/class_decision_drowsy_persist.sv | 64 ++++++
 rtl/class_decision.sv | 135 +++++++++++++
 tb/tb_class_decision.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/class_decision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : class_decision_pkg
// Description : Shared types and constants for the class decision block:
//               argmax FSM state encoding, class index names and default
//               drowsiness thresholds.
// Revision    : 1.0 - initial release
// ============================================================================
package class_decision_pkg;

    // Argmax sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    // Class index meaning at the output-neuron layer
    localparam int CLS_AWAKE  = 0;
    localparam int CLS_YAWN   = 1;
    localparam int CLS_DROWSY = 2;

    // Default decision thresholds
    localparam int DEF_MIN_CONF  = 256;
    localparam int DEF_ALARM_CNT = 4;

endpackage : class_decision_pkg
`default_nettype wire

// File: rtl/class_decision_drowsy_persist.sv
`default_nettype none
// ============================================================================
// Module      : drowsy_persist
// Description : Consecutive-drowsy-frame counter with sticky alarm.
//               Ports:
//                 clk        - system clock, rising edge
//                 rst_n      - asynchronous active-low reset
//                 update     - one-cycle strobe, a decision is being made
//                 drowsy     - decision qualifies as drowsy (valid with update)
//                 clear      - synchronous clear of counter and alarm
//                 drowsy_cnt - consecutive drowsy decisions, saturating
//                 alarm      - sticky alarm, set when count reaches ALARM_CNT
// Revision    : 1.0 - initial release
// ============================================================================
module drowsy_persist
    import class_decision_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int ALARM_CNT = DEF_ALARM_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update,
    input  logic             drowsy,
    input  logic             clear,
    output logic [CNT_W-1:0] drowsy_cnt,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(ALARM_CNT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturate at the alarm threshold so the counter never wraps
    assign w_cnt_inc = (r_cnt >= C_CNT_MAX) ? C_CNT_MAX : (r_cnt + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (clear) begin
            // Clear takes priority over a coincident decision
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (update) begin
            if (drowsy) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == C_CNT_MAX) begin
                    r_alarm <= 1'b1;
                end
            end else begin
                // Alarm is sticky; only the run length restarts
                r_cnt <= '0;
            end
        end
    end

    assign drowsy_cnt = r_cnt;
    assign alarm      = r_alarm;

endmodule : drowsy_persist
`default_nettype wire

// File: rtl/class_decision.sv
`default_nettype none
// ============================================================================
// Module      : class_decision
// Description : Sequential argmax over the output-neuron activations followed
//               by a confidence floor and a persistence counter that raises
//               the drowsiness alarm.
//               Ports:
//                 clk         - system clock, rising edge
//                 rst_n       - asynchronous active-low reset
//                 in_valid    - class_val holds a new frame result
//                 in_ready    - block can accept a frame (IDLE only)
//                 class_val   - output-neuron activations, unsigned
//                 clear       - synchronous clear of counter and alarm
//                 class_out   - winning class index of last decision
//                 confidence  - winning activation value
//                 class_valid - one-cycle pulse on a new decision
//                 drowsy_cnt  - current consecutive-drowsy count
//                 alarm       - sticky drowsiness alarm
// Revision    : 1.0 - initial release
// ============================================================================
module class_decision
    import class_decision_pkg::*;
#(
    parameter int               N_CLASS    = 3,
    parameter int               VAL_W      = 10,
    parameter int               IDX_W      = 2,
    parameter int               DROWSY_IDX = CLS_DROWSY,
    parameter logic [VAL_W-1:0] MIN_CONF   = VAL_W'(DEF_MIN_CONF),
    parameter int               ALARM_CNT  = DEF_ALARM_CNT,
    parameter int               CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] class_val [0:N_CLASS-1],
    input  logic             clear,
    output logic [IDX_W-1:0] class_out,
    output logic [VAL_W-1:0] confidence,
    output logic             class_valid,
    output logic [CNT_W-1:0] drowsy_cnt,
    output logic             alarm
);

    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(N_CLASS - 1);
    localparam logic [IDX_W-1:0] C_DROWSY_IDX = IDX_W'(DROWSY_IDX);

    state_t           r_state;
    logic [VAL_W-1:0] r_vals [0:N_CLASS-1];
    logic [VAL_W-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_class_out;
    logic [VAL_W-1:0] r_confidence;
    logic             r_class_valid;

    logic             w_update;
    logic             w_drowsy;

    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            for (int i = 0; i < N_CLASS; i++) begin
                r_vals[i] <= '0;
            end
            r_best        <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            r_class_out   <= '0;
            r_confidence  <= '0;
            r_class_valid <= 1'b0;
        end else begin
            r_class_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Snapshot the frame so upstream may change it freely
                        for (int i = 0; i < N_CLASS; i++) begin
                            r_vals[i] <= class_val[i];
                        end
                        r_best     <= class_val[0];
                        r_best_idx <= '0;
                        r_idx      <= IDX_W'(1);
                        r_state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    // Strict compare: ties keep the lower index
                    if (r_vals[r_idx] > r_best) begin
                        r_best     <= r_vals[r_idx];
                        r_best_idx <= r_idx;
                    end
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= DECIDE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DECIDE: begin
                    r_class_out   <= r_best_idx;
                    r_confidence  <= r_best;
                    r_class_valid <= 1'b1;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_update = (r_state == DECIDE);
    assign w_drowsy = (r_best_idx == C_DROWSY_IDX) && (r_best >= MIN_CONF);

    drowsy_persist #(
        .CNT_W     (CNT_W),
        .ALARM_CNT (ALARM_CNT)
    ) u_persist (
        .clk        (clk),
        .rst_n      (rst_n),
        .update     (w_update),
        .drowsy     (w_drowsy),
        .clear      (clear),
        .drowsy_cnt (drowsy_cnt),
        .alarm      (alarm)
    );

    assign class_out   = r_class_out;
    assign confidence  = r_confidence;
    assign class_valid = r_class_valid;

endmodule : class_decision
`default_nettype wire

// File: tb/tb_class_decision.sv
`default_nettype none
// ============================================================================
// Module      : tb_class_decision
// Description : Self-checking bench for class_decision: directed frames
//               followed by randomized frames against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_class_decision;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] cv [0:2];
    logic       clear;
    logic [1:0] class_out;
    logic [9:0] confidence;
    logic       class_valid;
    logic [3:0] drowsy_cnt;
    logic       alarm;

    int n_cmp = 0;
    int n_err = 0;

    // Reference persistence state
    int ref_cnt   = 0;
    bit ref_alarm = 1'b0;

    class_decision dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .class_val   (cv),
        .clear       (clear),
        .class_out   (class_out),
        .confidence  (confidence),
        .class_valid (class_valid),
        .drowsy_cnt  (drowsy_cnt),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference decision: first index holding the maximum value
    function automatic int ref_argmax(input int v0, input int v1, input int v2);
        int v [3];
        int b;
        v[0] = v0; v[1] = v1; v[2] = v2;
        b = 0;
        for (int i = 1; i < 3; i++) if (v[i] > v[b]) b = i;
        return b;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_cnt"},   drowsy_cnt, ref_cnt);
        chk({tag, "_alarm"}, alarm,      ref_alarm);
    endtask

    // One frame: accept, optionally hold junk on the input while busy,
    // optionally assert clear in the DECIDE cycle, then check the decision.
    task automatic frame(input int a, input int b, input int c,
                         input bit clr, input bit hold, input string tag);
        int lat;
        int widx;
        int wval;
        @(negedge clk);
        clear = 1'b0;
        chk({tag, "_ready"}, in_ready, 1);
        cv[0] = 10'(a); cv[1] = 10'(b); cv[2] = 10'(c);
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (hold && k <= 3) begin
                cv[0] = 10'($urandom); cv[1] = 10'($urandom); cv[2] = 10'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            clear = clr && (k == 3);
            if (k <= 3) chk({tag, "_busy_ready"}, in_ready, 0);
            @(posedge clk);
            #1;
            if (class_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 3);
        widx = ref_argmax(a, b, c);
        wval = (widx == 0) ? a : (widx == 1) ? b : c;
        if (clr) begin
            ref_cnt   = 0;
            ref_alarm = 1'b0;
        end else if (widx == 2 && wval >= 256) begin
            ref_cnt = (ref_cnt + 1 > 4) ? 4 : ref_cnt + 1;
            if (ref_cnt == 4) ref_alarm = 1'b1;
        end else begin
            ref_cnt = 0;
        end
        chk({tag, "_class"}, class_out,  widx);
        chk({tag, "_conf"},  confidence, wval);
        check_state(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        ref_cnt   = 0;
        ref_alarm = 1'b0;
        check_state(tag);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int seen;
        int mode;
        int a, b, c;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        cv[0] = '0; cv[1] = '0; cv[2] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", class_valid, 0);
        chk("rst_class", class_out, 0);
        chk("rst_conf",  confidence, 0);
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic argmax, tie handling, confidence floor
        frame(100, 200, 300, 0, 0, "basic");
        frame(500, 500, 100, 0, 0, "tie0");
        frame(50, 700, 700, 0, 0, "tie1");
        frame(10, 20, 200, 0, 0, "floor");
        frame(10, 20, 256, 0, 0, "floor_eq");
        frame(10, 20, 255, 0, 0, "floor_below");

        // Persistence, saturation, sticky alarm, clear
        for (int i = 0; i < 5; i++) frame(0, 0, 900, 0, (i == 1), $sformatf("persist%0d", i));
        frame(900, 0, 0, 0, 0, "sticky");
        do_clear("clear");

        // Clear coincident with DECIDE of a drowsy frame at count 3
        for (int i = 0; i < 3; i++) frame(0, 0, 900, 0, 0, $sformatf("pre%0d", i));
        frame(0, 0, 900, 1, 0, "clr_prio");

        // Reset while a frame is in COMPARE
        frame(0, 0, 900, 0, 0, "pre_rst");
        @(negedge clk);
        cv[0] = 10'd0; cv[1] = 10'd0; cv[2] = 10'd900;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        ref_cnt   = 0;
        ref_alarm = 1'b0;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", class_valid, 0);
        chk("midrst_class", class_out, 0);
        chk("midrst_conf",  confidence, 0);
        check_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (class_valid !== 1'b0) seen++;
        end
        chk("midrst_no_valid", seen, 0);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            a = $urandom_range(0, 1023);
            b = $urandom_range(0, 1023);
            c = $urandom_range(0, 1023);
            case (mode)
                1: begin a = $urandom_range(0, 200); b = $urandom_range(0, 200); c = $urandom_range(256, 1023); end
                2: begin b = a; c = ($urandom_range(0, 1) != 0) ? a : c; end
                3: begin a = $urandom_range(0, 240); b = $urandom_range(0, 240); c = $urandom_range(250, 262); end
                default: ;
            endcase
            frame(a, b, c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) != 0),
                  $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_class_decision
`default_nettype wire
